// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding and default sizes for the shift sequencer
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_reg_datapath.sv
// rtl/shift_reg_datapath.sv - right-shift register of per-bit load/shift mux cells
module shift_reg_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic             shift,
  input  logic             fill,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             shift_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             so_q;
  logic             so_d;

  // Each cell: load has priority over shift; with neither, the cell recirculates.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic upper;
    if (i == WIDTH - 1) begin : g_msb
      assign upper = fill;
    end else begin : g_mid
      assign upper = q_q[i+1];
    end
    assign q_d[i] = !load_n ? load_val[i] : (shift ? upper : q_q[i]);
  end

  assign so_d = !load_n ? 1'b0 : (shift ? q_q[0] : so_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign q         = q_q;
  assign shift_out = so_q;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - LOAD-then-SHIFT sequencer driving one shift_reg_datapath
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] num_shifts,
  input  logic             asr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             asr_q, asr_d;
  logic             dp_load_n;
  logic             dp_shift;
  logic             dp_fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      asr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      asr_q   <= asr_d;
    end
  end

  // Datapath controls are gated by abort so a cancelled cycle leaves q untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    asr_d     = asr_q;
    dp_load_n = 1'b1;
    dp_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = load_val;
          asr_d   = asr;
          cnt_d   = (num_shifts > MAX_CNT) ? MAX_CNT : num_shifts;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dp_load_n = 1'b0;
          state_d   = (cnt_q == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dp_shift = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dp_fill = asr_q & q[WIDTH-1];
  assign busy    = (state_q == LOAD) || (state_q == SHIFT);
  assign done    = (state_q == DONE);

  shift_reg_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_n   (dp_load_n),
    .shift    (dp_shift),
    .fill     (dp_fill),
    .load_val (val_q),
    .q        (q),
    .shift_out(serial_out)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] load_val;
  logic [3:0] num_shifts;
  logic       asr;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic       serial_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .load_val  (load_val),
    .num_shifts(num_shifts),
    .asr       (asr),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .serial_out(serial_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an operation on a falling edge and walks it to completion, checking the
  // busy length, the done latency (in samples after the start edge) and the result.
  task automatic run_op(input string tag, input logic [7:0] lv, input logic [3:0] n,
                        input logic a, input logic abort_with_start, input int exp_busy,
                        input logic [7:0] exp_q, input logic exp_so);
    int k;
    int nb;
    load_val   = lv;
    num_shifts = n;
    asr        = a;
    abort      = abort_with_start;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    k  = 1;
    nb = 0;
    while (done !== 1'b1 && k < 30) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_done_latency"}, k, exp_busy + 1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
    chk({tag, "_serial_out"}, {31'd0, serial_out}, {31'd0, exp_so});
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    chk({tag, "_q_stable"}, {24'd0, q}, {24'd0, exp_q});
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    load_val   = 8'h00;
    num_shifts = 4'd0;
    asr        = 1'b0;
    abort      = 1'b0;
    #2;
    chk("reset_q", {24'd0, q}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_so", {31'd0, serial_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("lsr3", 8'h96, 4'd3, 1'b0, 1'b0, 4, 8'h12, 1'b1);
    run_op("asr2", 8'hA5, 4'd2, 1'b1, 1'b0, 3, 8'hE9, 1'b0);
    run_op("n0", 8'h3C, 4'd0, 1'b0, 1'b0, 1, 8'h3C, 1'b0);
    run_op("sat_asr", 8'h80, 4'd15, 1'b1, 1'b0, 9, 8'hFF, 1'b1);
    run_op("sat_lsr", 8'h80, 4'd15, 1'b0, 1'b0, 9, 8'h00, 1'b1);
    run_op("start_beats_abort", 8'h5A, 4'd1, 1'b0, 1'b1, 2, 8'h2D, 1'b0);

    // Abort after two shifts; a stray start mid-SHIFT must not disturb the run.
    load_val   = 8'hF0;
    num_shifts = 4'd4;
    asr        = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("ab_loaded", {24'd0, q}, 32'h0000_00F0);
    load_val   = 8'h11;
    num_shifts = 4'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_shift1", {24'd0, q}, 32'h0000_0078);
    @(negedge clk);
    chk("ab_shift2", {24'd0, q}, 32'h0000_003C);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle_busy", {31'd0, busy}, 32'd0);
    chk("ab_held_q", {24'd0, q}, 32'h0000_003C);
    for (int i = 0; i < 3; i++) begin
      chk("ab_no_done", {31'd0, done}, 32'd0);
      chk("ab_q_hold", {24'd0, q}, 32'h0000_003C);
      @(negedge clk);
    end

    // Asynchronous reset between edges while shifting.
    load_val   = 8'hFF;
    num_shifts = 4'd5;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_q", {24'd0, q}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    chk("rst_async_so", {31'd0, serial_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 8'h01, 4'd1, 1'b0, 1'b0, 2, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that sequences a WIDTH-bit right-shift register built from per-bit load/shift cells. It accepts a start request with a load value and a shift count. It then drives the register's load and shift controls through a fixed LOAD-then-SHIFT sequence, and signals completion with a one-cycle done pulse. It sits between switch/FSM-level control and the shift-register datapath, and owns all load_n/shift/fill sequencing for it.

Parameters:
WIDTH, 8, register width in bits
CNT_W, 4, width of shift-count input; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
load_val  input  WIDTH  parallel value to load
num_shifts  input  CNT_W  number of right shifts to perform
asr  input  1  1 = arithmetic fill (MSB replicated), 0 = logical fill (0)
abort  input  1  synchronous cancel of an operation in progress
busy  output  1  high in LOAD and SHIFT
done  output  1  one-cycle pulse when the operation completes
q  output  WIDTH  current register contents
serial_out  output  1  last bit shifted out of q[0]

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (reset_n). Assertion immediately forces state=IDLE, q=0, busy=0, done=0, serial_out=0, and clears latched operands. No clock edge is needed.
- States (2-bit): IDLE, LOAD, SHIFT, DONE.
- IDLE: busy=0.
  - If start=1 at an edge: latch load_val, asr, and cnt=min(num_shifts, WIDTH); go to LOAD.
  - Otherwise hold.
  - q holds its previous result.
- LOAD: busy=1; datapath load_n=0.
  - At next edge: q<=latched load_val; serial_out<=0.
  - Then go to DONE if cnt==0, else SHIFT.
- SHIFT: busy=1; datapath shift=1, load_n=1. Each edge:
  - q<={fill, q[WIDTH-1:1]}, with fill = asr ? q[WIDTH-1] : 0.
  - serial_out<=q[0]; cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
- DONE: done=1, busy=0, q stable; next edge goes to IDLE. A start in DONE is ignored.
- Latency: start accepted at edge E0; q loaded at E1; shifts at E2..E(N+1); done high during the cycle after edge E(N+1) (N=0: after E1).
- start while busy or in DONE: ignored, not queued.
- abort=1 in LOAD or SHIFT: next edge goes to IDLE. q keeps its value (no further shift/load), no done pulse. abort is ignored in IDLE/DONE. abort and start together in IDLE: start wins.
- num_shifts > WIDTH saturates to WIDTH: result is all-fill.
- Datapath fed only by this block; no external load/shift path exists.

Decomposition:
- Package shift_seq_pkg:
  - state encoding constants: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11
  - default WIDTH=8, CNT_W=4
- Sub-module shift_reg_datapath (WIDTH cells, each a 2-level mux + flop):
  - inputs: clk, reset_n (async active-low), load_n, shift, fill, load_val
  - outputs: q, shifted-out bit
- shift_sequencer contains the FSM, counter and operand latches, and instantiates one shift_reg_datapath.

Test Plan:
- WIDTH=8, load_val=8'h96, num_shifts=3, asr=0, start pulse → busy for 4 cycles; done at cycle after E4; q=8'h12, serial_out=1.
- load_val=8'hA5, num_shifts=2, asr=1 → q=8'hE9, serial_out=0, done after E3.
- num_shifts=0, load_val=8'h3C → no SHIFT state, done after E1, q=8'h3C, serial_out=0.
- num_shifts=15 saturates:
  - load_val=8'h80, asr=1 → q=8'hFF after 8 shifts, done after E9.
  - asr=0 → q=8'h00.
- Start 8'hF0/N=4 asr=0, then pulse start during SHIFT → ignored. Assert abort after 2 shifts → q=8'h3C held, IDLE next edge, done never asserted.
- Drive reset_n low mid-SHIFT between clock edges → q=0, busy=0, done=0 immediately. Release, then start 8'h01/N=1 → q=8'h00, serial_out=1.
